// File: rtl/mem_burst_responder_if.sv
// ---------------------------------------------------------------------------
// mem_burst_responder_if
//   Request/response bus between a CPU-side master and mem_burst_responder.
//
//   Request channel  (master -> slave): req_valid, req_write, req_burst,
//                                       req_addr[15:0], req_wdata[15:0]
//   Request ready    (slave -> master): req_ready
//   Response channel (slave -> master): resp_valid, resp_data[15:0], resp_last
//   Status           (slave -> master): busy (always ~req_ready)
//
//   There is no response back-pressure: the master must take every response.
// ---------------------------------------------------------------------------
interface mem_burst_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_burst;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        resp_last;
    logic        busy;

    modport master (
        output req_valid, req_write, req_burst, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data, resp_last, busy
    );

    modport slave (
        input  req_valid, req_write, req_burst, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data, resp_last, busy
    );
endinterface

// File: rtl/mem_burst_responder.sv
// ---------------------------------------------------------------------------
// mem_burst_responder
//   Single-outstanding memory responder with a fixed response latency.
//   Accepts a write, a single-word read or an 8-word line read, and returns
//   responses exactly LATENCY rising edges after each word is issued.
//
//   Parameters
//     LATENCY  edges from issue of a word to its response cycle (1..8)
//     DEPTH_W  log2 of the memory depth in 16-bit words (3..15)
//
//   Ports
//     clk    single clock, rising-edge
//     rst_n  asynchronous active-low reset
//     bus    mem_burst_responder_if.slave (request, response, busy)
//
//   Word index is req_addr[DEPTH_W:1]. A line read starts at the index with
//   its low three bits cleared and issues one word per cycle, the first on
//   the accepting edge. Memory contents survive reset.
// ---------------------------------------------------------------------------
module mem_burst_responder #(
    parameter int LATENCY = 4,
    parameter int DEPTH_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mem_burst_responder_if.slave    bus
);

    localparam int DEPTH = 1 << DEPTH_W;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    // One entry of the response pipeline.
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } beat_t;

    logic [15:0]        r_mem [DEPTH];
    state_t             r_state;
    logic               r_req_ready;
    logic [2:0]         r_beat;          // index of the next line word to issue
    logic [DEPTH_W-1:0] r_base;          // line-aligned word index of the burst
    // Stage 0 holds the word issued on the last edge; stages 1..LATENCY delay
    // it so that stage LATENCY is presented exactly LATENCY edges after issue.
    beat_t              r_pipe [LATENCY+1];

    logic               w_accept;
    logic [DEPTH_W-1:0] w_req_idx;
    logic [DEPTH_W-1:0] w_burst_base;
    logic [DEPTH_W-1:0] w_rd_idx;
    beat_t              w_issue;
    logic               w_unused_addr;

    assign w_accept     = bus.req_valid & r_req_ready;
    assign w_req_idx    = bus.req_addr[DEPTH_W:1];
    assign w_burst_base = {w_req_idx[DEPTH_W-1:3], 3'b000};
    // Address bit 0 and bits above DEPTH_W carry no meaning here.
    assign w_unused_addr = ^bus.req_addr;

    // Word entering the pipeline on the coming edge (all-zero when nothing
    // is issued, which also keeps resp_data at 0 outside response cycles).
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        w_rd_idx = w_req_idx;
        w_issue  = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (bus.req_write) begin
                        w_issue.valid = 1'b1;
                        w_issue.last  = 1'b1;
                    end else if (bus.req_burst) begin
                        w_rd_idx      = w_burst_base;
                        w_issue.valid = 1'b1;
                        w_issue.data  = r_mem[w_rd_idx];
                    end else begin
                        w_issue.valid = 1'b1;
                        w_issue.last  = 1'b1;
                        w_issue.data  = r_mem[w_rd_idx];
                    end
                end
            end
            ISSUE: begin
                // Index arithmetic is DEPTH_W bits wide, so it wraps by itself.
                w_rd_idx      = r_base + DEPTH_W'(r_beat);
                w_issue.valid = 1'b1;
                w_issue.last  = (r_beat == 3'd7);
                w_issue.data  = r_mem[w_rd_idx];
            end
            default: ;
        endcase
    end

    // NOTE: the memory array has no reset branch; its contents must survive
    // rst_n, and a resettable array would not map onto RAM.
    always_ff @(posedge clk) begin
        if (rst_n && w_accept && bus.req_write) begin
            r_mem[w_req_idx] <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_beat      <= '0;
            r_base      <= '0;
            for (int i = 0; i <= LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_issue;
            for (int i = 1; i <= LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        if (!bus.req_write && bus.req_burst) begin
                            r_state <= ISSUE;
                            r_base  <= w_burst_base;
                            r_beat  <= 3'd1;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end
                end
                ISSUE: begin
                    r_beat <= r_beat + 3'd1;
                    if (r_beat == 3'd7) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave on the edge that ends the final response cycle.
                    if (r_pipe[LATENCY].valid && r_pipe[LATENCY].last) begin
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.busy       = ~r_req_ready;
    assign bus.resp_valid = r_pipe[LATENCY].valid;
    assign bus.resp_last  = r_pipe[LATENCY].last;
    assign bus.resp_data  = r_pipe[LATENCY].data;

endmodule

// File: tb/tb_mem_burst_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_burst_responder
//   Randomised scoreboard bench for mem_burst_responder (LATENCY=4,
//   DEPTH_W=10) plus a short directed sequence on a LATENCY=1 instance.
//   The driver predicts each response (data, last flag, cycle) from a
//   word-array model at accept time; an independent monitor pops and
//   compares whenever resp_valid is seen.
// ---------------------------------------------------------------------------
module tb_mem_burst_responder;

    localparam int LAT   = 4;
    localparam int DW    = 10;
    localparam int DEPTH = 1 << DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_burst_responder_if bus  ();
    mem_burst_responder_if bus1 ();

    mem_burst_responder #(.LATENCY(LAT), .DEPTH_W(DW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mem_burst_responder #(.LATENCY(1), .DEPTH_W(DW)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [15:0] ref_mem [DEPTH];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory word addressed by a byte address.
    function automatic int word_idx(input logic [15:0] addr);
        return (int'(addr) / 2) % DEPTH;
    endfunction

    // Memory word for line word k: line base is the address rounded down to 16.
    function automatic int line_idx(input logic [15:0] addr, input int k);
        return ((int'(addr) - int'(addr) % 16 + 2 * k) / 2) % DEPTH;
    endfunction

    // Issue one request, predict its responses, and check how long the
    // responder stays unavailable. Returns at a falling edge with req_ready=1.
    // keep_valid leaves req_valid high (with junk fields) while busy.
    task automatic do_req(input bit wr, input bit bt, input logic [15:0] addr,
                          input logic [15:0] wdata, input bit keep_valid);
        int   t;
        int   acc;
        int   n;
        exp_t e;
        bus.req_write = wr;
        bus.req_burst = bt;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        t = 0;
        while (bus.req_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (bus.req_ready !== 1'b1) begin
            check("accept_timeout", bus.req_ready, 1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (wr) begin
            ref_mem[word_idx(addr)] = wdata;
            e = '{data: 16'h0, last: 1'b1, cyc: acc + LAT};
            exp_q.push_back(e);
        end else if (bt) begin
            for (int k = 0; k < 8; k++) begin
                e = '{data: ref_mem[line_idx(addr, k)], last: (k == 7), cyc: acc + LAT + k};
                exp_q.push_back(e);
            end
        end else begin
            e = '{data: ref_mem[word_idx(addr)], last: 1'b1, cyc: acc + LAT};
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_burst = 1'($urandom_range(0, 1));
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = 16'($urandom);
        if (!keep_valid) bus.req_valid = 1'b0;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_low_cycles", n, (!wr && bt) ? LAT + 8 : LAT + 1);
    endtask

    // Monitor: compares every presented response against the scoreboard.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("busy_is_not_ready", bus.busy, !bus.req_ready);
            if (bus.resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", bus.resp_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_data",  bus.resp_data, mon_e.data);
                    check("resp_last",  bus.resp_last, mon_e.last);
                    check("resp_cycle", cyc, mon_e.cyc);
                end
            end else begin
                check("idle_resp_data", bus.resp_data, 0);
                check("idle_resp_last", bus.resp_last, 0);
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t expected earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        bit          keep;
        int          op;
        logic [15:0] a;

        bus.req_valid  = 1'b0; bus.req_write  = 1'b0; bus.req_burst  = 1'b0;
        bus.req_addr   = '0;   bus.req_wdata  = '0;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_burst = 1'b0;
        bus1.req_addr  = '0;   bus1.req_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready",      bus.req_ready,  1);
        check("rst_busy",       bus.busy,       0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_last",  bus.resp_last,  0);
        check("rst_resp_data",  bus.resp_data,  0);
        check("rst1_ready",     bus1.req_ready, 1);
        check("rst1_resp_valid", bus1.resp_valid, 0);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Fill the whole memory; junk in ignored address bits, valid held high.
        for (int i = 0; i < DEPTH; i++) begin
            a = 16'(($urandom_range(0, 31) << 11) | (i << 1) | $urandom_range(0, 1));
            do_req(1'b1, 1'b0, a, 16'($urandom), i != DEPTH - 1);
        end

        // Write then single read of the same word
        do_req(1'b1, 1'b0, 16'h0024, 16'hBEEF, 1'b0);
        do_req(1'b0, 1'b0, 16'h0024, 16'h0000, 1'b0);

        // Line read from a mid-line address
        for (int k = 0; k < 8; k++) do_req(1'b1, 1'b0, 16'(16'h0030 + 2 * k), 16'(16'h1000 + k), 1'b0);
        do_req(1'b0, 1'b1, 16'h0036, 16'h0000, 1'b0);

        // Lines at the top of memory and beyond its address range
        do_req(1'b0, 1'b1, 16'h07F0, 16'h0000, 1'b0);
        do_req(1'b0, 1'b1, 16'h0FF8, 16'h0000, 1'b0);
        do_req(1'b0, 1'b1, 16'hFFFE, 16'h0000, 1'b0);

        // Back-to-back single reads with req_valid held continuously
        for (int i = 0; i < 20; i++) do_req(1'b0, 1'b0, 16'($urandom), 16'h0000, i != 19);

        // Random mix
        for (int i = 0; i < 300; i++) begin
            op   = $urandom_range(0, 2);
            keep = (i != 299) && ($urandom_range(0, 1) == 1);
            do_req(op == 0, op == 2, 16'($urandom), 16'($urandom), keep);
            if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during word 3 of a line read
        do_req(1'b1, 1'b0, 16'h0200, 16'hC0DE, 1'b0);
        bus.req_write = 1'b0;
        bus.req_burst = 1'b1;
        bus.req_addr  = 16'h0200;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        for (int k = 0; k < 8; k++) exp_q.push_back('{data: ref_mem[line_idx(16'h0200, k)], last: (k == 7), cyc: acc + LAT + k});
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (cyc < acc + LAT + 3) @(negedge clk);
        #1;
        check("words_before_reset", exp_q.size(), 4);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_resp_valid", bus.resp_valid, 0);
        check("mid_rst_resp_last",  bus.resp_last,  0);
        check("mid_rst_resp_data",  bus.resp_data,  0);
        check("mid_rst_ready",      bus.req_ready,  1);
        check("mid_rst_busy",       bus.busy,       0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        do_req(1'b0, 1'b1, 16'h0200, 16'h0000, 1'b0);
        do_req(1'b0, 1'b0, 16'h0024, 16'h0000, 1'b0);

        // LATENCY=1 instance: write ack and read one cycle after the accept cycle
        @(negedge clk);
        bus1.req_write = 1'b1;
        bus1.req_addr  = 16'h0100;
        bus1.req_wdata = 16'h5A5A;
        bus1.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.req_valid = 1'b0;
        check("l1_wr_acc_cycle_valid", bus1.resp_valid, 0);
        check("l1_wr_acc_cycle_ready", bus1.req_ready,  0);
        @(negedge clk);
        check("l1_wr_ack_valid", bus1.resp_valid, 1);
        check("l1_wr_ack_last",  bus1.resp_last,  1);
        check("l1_wr_ack_data",  bus1.resp_data,  0);
        @(negedge clk);
        check("l1_wr_ready_after", bus1.req_ready, 1);
        bus1.req_write = 1'b0;
        bus1.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.req_valid = 1'b0;
        check("l1_rd_acc_cycle_valid", bus1.resp_valid, 0);
        @(negedge clk);
        check("l1_rd_valid", bus1.resp_valid, 1);
        check("l1_rd_data",  bus1.resp_data,  16'h5A5A);
        check("l1_rd_last",  bus1.resp_last,  1);
        check("l1_rd_busy",  bus1.busy,       1);
        @(negedge clk);
        check("l1_rd_ready_after", bus1.req_ready, 1);
        check("l1_rd_valid_after", bus1.resp_valid, 0);

        // Every predicted response must have appeared
        repeat (LAT + 12) @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
